regfile_dump: RTL and testbench

- Sequential reader on a spare read port of the CPU register file. It walks a programmable register range and streams each 32-bit value, tagged with its register number, out over a valid/ready handshake.
- Consumers are the debug UART/trace path, and the testbench at end of program.
- It is a pure reader. It never writes the register file.

---
 rtl/regdump_pkg.sv | 20 ++
 rtl/regfile_dump.sv | 156 +++++++++++++++
 tb/tb_regfile_dump.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regdump_pkg.sv
// regdump_pkg: shared types and constants for the register-file dump engine.
//   state_t    : dump FSM states (CSUM is only reachable with REGDUMP_CHECKSUM_EN)
//   DEF_ADDR_W : default register index width
//   DEF_DATA_W : default register data width
//   NUM_REGS   : number of architectural registers walked by the dump
package regdump_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND,
        CSUM,
        DONE
    } state_t;

endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: walks a programmable register range (first_reg..last_reg,
// wrapping from 31 to 0) on a spare register-file read port and streams each
// value, tagged with its index, out over a valid/ready handshake. It never
// writes the register file.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   start      : one-cycle dump request, ignored while busy
//   first_reg  : first register index, sampled on accepted start
//   last_reg   : last register index, sampled on accepted start
//   rd_addr    : address to the register-file read port
//   rd_data    : combinational read data from the register file
//   out_valid  : stream word valid
//   out_ready  : downstream accepts the word
//   out_data   : register value (or checksum word)
//   out_addr   : register index of out_data (0 for the checksum word)
//   out_last   : final word of the dump
//   busy       : high from accepted start through the DONE cycle
//   done       : one-cycle pulse after the final word is accepted
//
// Build option: define REGDUMP_CHECKSUM_EN to append an XOR checksum word
// after the register words; out_last then marks only the checksum word.
module regfile_dump
    import regdump_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] end_idx;
    logic [ADDR_W-1:0] next_idx;
    logic              at_end;
    logic              xfer;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    assign at_end = (cur == end_idx);
    assign xfer   = out_valid & out_ready;

    // Index following cur; the walk wraps from the top register back to 0.
    assign next_idx = (32'(cur) == 32'(NUM_REGS - 1)) ? '0 : cur + 1'b1;

    // rd_addr is set up on the transition into READ so the register file
    // presents the word during the READ cycle, where it is captured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur       <= '0;
            end_idx   <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur     <= first_reg;
                        end_idx <= last_reg;
                        rd_addr <= first_reg;
                        busy    <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                        csum    <= '0;
`endif
                        state   <= READ;
                    end
                end

                READ: begin
                    out_data  <= rd_data;
                    out_addr  <= cur;
`ifdef REGDUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= at_end;
`endif
                    out_valid <= 1'b1;
                    state     <= SEND;
                end

                SEND: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                        csum      <= csum ^ out_data;
`endif
                        if (at_end) begin
`ifdef REGDUMP_CHECKSUM_EN
                            // Checksum word includes the register word
                            // being accepted in this same cycle.
                            out_data  <= csum ^ out_data;
                            out_addr  <= '0;
                            out_last  <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= CSUM;
`else
                            done      <= 1'b1;
                            state     <= DONE;
`endif
                        end else begin
                            cur     <= next_idx;
                            rd_addr <= next_idx;
                            state   <= READ;
                        end
                    end
                end

`ifdef REGDUMP_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: self-checking bench for regfile_dump. Models a 32-entry
// register file around the DUT and predicts every streamed word from the
// range arithmetic and a shadow copy of the register contents.
// Honours REGDUMP_CHECKSUM_EN when the DUT is built with it.
module tb_regfile_dump;
    import regdump_pkg::*;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int CSUM_WORDS = 1;
`else
    localparam int CSUM_WORDS = 0;
`endif

    typedef struct {
        logic [4:0] firstReg;
        logic [4:0] lastReg;
        int         stall;
        bit         randReady;
        int         expWords;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  firstReg = '0;
    logic [4:0]  lastReg = '0;
    logic [4:0]  rdAddr;
    logic [31:0] rdData;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] outData;
    logic [4:0]  outAddr;
    logic        outLast;
    logic        busy;
    logic        done;

    logic        wrEn = 1'b0;
    logic [4:0]  wrAddr = '0;
    logic [31:0] wrData = '0;
    logic [31:0] rfMem [32];
    logic [31:0] modelRegs [32];

    int checks = 0;
    int failures = 0;

    vec_t vecs [5];

    always #5 clk = ~clk;

    // Register file: synchronous write, combinational read, index 0 reads 0.
    always @(posedge clk) begin
        if (wrEn) rfMem[wrAddr] <= wrData;
    end
    assign rdData = (rdAddr == 5'd0) ? 32'd0 : rfMem[rdAddr];

    regfile_dump dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_reg (firstReg),
        .last_reg  (lastReg),
        .rd_addr   (rdAddr),
        .rd_data   (rdData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_addr  (outAddr),
        .out_last  (outLast),
        .busy      (busy),
        .done      (done)
    );

    // One comparison; every failure prints a single FAIL line.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Whole stream word: valid, addr, data, last.
    task automatic checkWord(input string name, input logic [4:0] expAddr,
                             input logic [31:0] expData, input logic expLast);
        checkOutput(name, 64'({outValid, outAddr, outData, outLast}),
                    64'({1'b1, expAddr, expData, expLast}));
    endtask

    task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        wrEn = 1'b1;
        wrAddr = addr;
        wrData = data;
        modelRegs[addr] = data;
        @(negedge clk);
        wrEn = 1'b0;
    endtask

    // Expected register value as the dump sees it: register 0 is always 0.
    function automatic logic [31:0] regValue(input logic [4:0] addr);
        return (addr == 5'd0) ? 32'd0 : modelRegs[addr];
    endfunction

    // Runs one dump and checks every word, the spacing, holds under stall,
    // the done pulse and the return to idle.
    task automatic applyStimulus(input vec_t v);
        int          gap;
        int          stall;
        bit          isCsum;
        logic [4:0]  expAddr;
        logic [31:0] expData;
        logic        expLast;
        logic [31:0] acc;
        acc = '0;
        @(negedge clk);
        start = 1'b1;
        firstReg = v.firstReg;
        lastReg = v.lastReg;
        outReady = 1'b0;
        @(negedge clk);
        start = 1'b0;
        firstReg = 5'($urandom);
        lastReg = 5'($urandom);
        checkOutput("busy_after_start", 64'(busy), 64'(1));
        for (int k = 0; k < v.expWords + CSUM_WORDS; k++) begin
            gap = 0;
            while (!outValid && gap < 10) begin
                outReady = v.randReady ? 1'($urandom) : 1'b0;
                start = v.randReady ? 1'($urandom) : 1'b0;
                firstReg = 5'($urandom);
                lastReg = 5'($urandom);
                @(negedge clk);
                gap++;
            end
            start = 1'b0;
            if (!outValid) begin
                checkOutput("valid_timeout", 64'(0), 64'(1));
                return;
            end
            if (k > 0) checkOutput("word_spacing", 64'(gap), 64'(1));
            isCsum = (k == v.expWords);
            expAddr = isCsum ? 5'd0 : 5'((int'(v.firstReg) + k) % 32);
            expData = isCsum ? acc : regValue(expAddr);
            expLast = (CSUM_WORDS == 1) ? isCsum : (k == v.expWords - 1);
            stall = v.randReady ? $urandom_range(0, v.stall) : v.stall;
            outReady = 1'b0;
            for (int s = 0; s < stall; s++) begin
                checkWord("stall_hold", expAddr, expData, expLast);
                @(negedge clk);
            end
            checkWord("word", expAddr, expData, expLast);
            if (!isCsum) acc = acc ^ expData;
            outReady = 1'b1;
            @(negedge clk);
            outReady = 1'b0;
            checkOutput("valid_drop", 64'(outValid), 64'(0));
        end
        checkOutput("done_pulse", 64'({done, busy}), 64'(2'b11));
        start = v.randReady;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_clear", 64'({done, busy}), 64'(2'b00));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t rv;
        logic [31:0] expSum;
        bit sawDone;
        vecs[0] = '{5'd0,  5'd31, 0, 1'b0, 32};
        vecs[1] = '{5'd30, 5'd1,  0, 1'b0, 4};
        vecs[2] = '{5'd5,  5'd6,  7, 1'b0, 2};
        vecs[3] = '{5'd3,  5'd3,  0, 1'b0, 1};
        vecs[4] = '{5'd31, 5'd0,  2, 1'b1, 2};
        for (int i = 0; i < 32; i++) modelRegs[i] = '0;

        // Reset state.
        #1 reset = 1'b0;
        #3;
        checkOutput("reset_outputs",
                    64'({rdAddr, outValid, outData, outAddr, outLast, busy, done}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 1; i < 32; i++) writeReg(5'(i), 32'h1000_0000 + i);

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        // Write to R7 in its own READ cycle: the pre-write value is dumped.
        @(negedge clk);
        start = 1'b1; firstReg = 5'd6; lastReg = 5'd8; outReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkWord("cw_r6", 5'd6, 32'h1000_0006, 1'b0);
        @(negedge clk);
        checkOutput("cw_rd_addr", 64'(rdAddr), 64'(7));
        wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'hDEAD_BEEF;
        @(negedge clk);
        wrEn = 1'b0;
        modelRegs[7] = 32'hDEAD_BEEF;
        checkWord("cw_r7_old", 5'd7, 32'h1000_0007, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkWord("cw_r8", 5'd8, 32'h1000_0008, (CSUM_WORDS == 0));
`ifdef REGDUMP_CHECKSUM_EN
        @(negedge clk);
        checkWord("cw_csum", 5'd0, 32'h1000_0009, 1'b1);
`endif
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("cw_done", 64'({done, busy}), 64'(2'b11));
        @(negedge clk);
        checkOutput("cw_rf_written", 64'(rfMem[7]), 64'(32'hDEAD_BEEF));
        writeReg(5'd7, 32'h1000_0007);

        // Start while busy is ignored, then reset aborts mid-SEND.
        @(negedge clk);
        start = 1'b1; firstReg = 5'd10; lastReg = 5'd20;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkWord("busy_r10", 5'd10, 32'h1000_000A, 1'b0);
        start = 1'b1; firstReg = 5'd0; lastReg = 5'd0; outReady = 1'b1;
        @(negedge clk);
        start = 1'b0; outReady = 1'b0;
        @(negedge clk);
        checkWord("busy_r11", 5'd11, 32'h1000_000B, 1'b0);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_outputs",
                    64'({rdAddr, outValid, outData, outAddr, outLast, busy, done}), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        sawDone = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || outValid || busy) sawDone = 1'b1;
        end
        checkOutput("abort_quiet", 64'(sawDone), 64'(0));
        applyStimulus('{5'd3, 5'd3, 0, 1'b0, 1});

        // Checksum of 1..3 collapses to 0x10000000 when the feature is on.
        expSum = 32'h1000_0001 ^ 32'h1000_0002 ^ 32'h1000_0003;
        checkOutput("csum_model", 64'(expSum), 64'(32'h1000_0000));
        applyStimulus('{5'd1, 5'd3, 1, 1'b1, 3});

        // Randomized ranges, register contents, stalls and spurious starts.
        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 3; w++) writeReg(5'($urandom_range(1, 31)), $urandom);
            rv.firstReg = 5'($urandom);
            rv.lastReg = 5'($urandom);
            rv.stall = 3;
            rv.randReady = 1'b1;
            rv.expWords = ((int'(rv.lastReg) - int'(rv.firstReg) + 32) % 32) + 1;
            applyStimulus(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
